// File: rtl/mem_arb_pkg.sv
// Shared types and default widths for the fetch/data memory arbiter.
package mem_arb_pkg;

  localparam int AW_DEF         = 6;
  localparam int DW_DEF         = 32;
  localparam int STARVE_MAX_DEF = 4;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    WAIT
  } arb_state_t;

  typedef enum logic {
    GNT_IF,
    GNT_D
  } gnt_t;

endpackage

// File: rtl/mem_arbiter_select.sv
// Winner selection for mem_arbiter: data priority with a fetch starvation guard,
// or round-robin on ties when MEM_ARB_RR_EN is defined.
module arb_select
  import mem_arb_pkg::*;
#(
  parameter int STARVE_MAX = STARVE_MAX_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic if_req,
  input  logic d_req,
  input  logic take,
  output gnt_t winner
);

`ifdef MEM_ARB_RR_EN

  gnt_t last_gnt_q, last_gnt_d;

  always_comb begin
    winner = d_req ? GNT_D : GNT_IF;
    if (if_req && d_req) begin
      winner = (last_gnt_q == GNT_IF) ? GNT_D : GNT_IF;
    end
    last_gnt_d = take ? winner : last_gnt_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      last_gnt_q <= GNT_IF;
    end else begin
      last_gnt_q <= last_gnt_d;
    end
  end

`else

  localparam int CW = $clog2(STARVE_MAX + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(STARVE_MAX);

  logic [CW-1:0] starve_cnt_q, starve_cnt_d;

  always_comb begin
    winner = GNT_IF;
    if (d_req && !(if_req && (starve_cnt_q == CNT_MAX))) begin
      winner = GNT_D;
    end
    starve_cnt_d = starve_cnt_q;
    if (take) begin
      // Only a data grant that made a waiting fetch wait longer counts.
      if ((winner == GNT_D) && if_req) begin
        starve_cnt_d = (starve_cnt_q == CNT_MAX) ? CNT_MAX : starve_cnt_q + 1'b1;
      end else begin
        starve_cnt_d = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      starve_cnt_q <= '0;
    end else begin
      starve_cnt_q <= starve_cnt_d;
    end
  end

`endif

endmodule

// File: rtl/mem_arbiter.sv
// Shares one synchronous-read memory between fetch and load/store through an
// IDLE -> ACCESS -> WAIT sequence. Optional macro: MEM_ARB_RR_EN (round-robin ties).
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int AW         = AW_DEF,
  parameter int DW         = DW_DEF,
  parameter int STARVE_MAX = STARVE_MAX_DEF
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic [DW-1:0] if_rdata,
  output logic          if_ack,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic [DW-1:0] d_rdata,
  output logic          d_ack,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  arb_state_t    state_q, state_d;
  gnt_t          gnt_q, gnt_d;
  logic          we_q, we_d;
  logic          mem_en_q, mem_en_d;
  logic          mem_we_q, mem_we_d;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic [DW-1:0] mem_wdata_q, mem_wdata_d;
  logic          if_ack_q, if_ack_d;
  logic          d_ack_q, d_ack_d;
  logic [DW-1:0] if_rdata_q, if_rdata_d;
  logic [DW-1:0] d_rdata_q, d_rdata_d;

  gnt_t winner;
  logic take;

  assign take = (state_q == IDLE) && (if_req || d_req);

  arb_select #(
    .STARVE_MAX(STARVE_MAX)
  ) u_select (
    .clk   (clk),
    .reset (reset),
    .if_req(if_req),
    .d_req (d_req),
    .take  (take),
    .winner(winner)
  );

  always_comb begin
    state_d     = state_q;
    gnt_d       = gnt_q;
    we_d        = we_q;
    mem_en_d    = 1'b0;
    mem_we_d    = 1'b0;
    mem_addr_d  = '0;
    mem_wdata_d = '0;
    if_ack_d    = 1'b0;
    d_ack_d     = 1'b0;
    if_rdata_d  = if_rdata_q;
    d_rdata_d   = d_rdata_q;
    case (state_q)
      IDLE: begin
        if (take) begin
          gnt_d    = winner;
          mem_en_d = 1'b1;
          state_d  = ACCESS;
          if (winner == GNT_D) begin
            we_d        = d_we;
            mem_we_d    = d_we;
            mem_addr_d  = d_addr;
            mem_wdata_d = d_wdata;
          end else begin
            we_d       = 1'b0;
            mem_addr_d = if_addr;
          end
        end
      end
      ACCESS: begin
        state_d = WAIT;
      end
      WAIT: begin
        // Memory read data is valid this cycle; hand it to whoever was granted.
        state_d = IDLE;
        if (gnt_q == GNT_D) begin
          d_ack_d = 1'b1;
          if (!we_q) begin
            d_rdata_d = mem_rdata;
          end
        end else begin
          if_ack_d   = 1'b1;
          if_rdata_d = mem_rdata;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      gnt_q       <= GNT_IF;
      we_q        <= 1'b0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_ack_q    <= 1'b0;
      d_ack_q     <= 1'b0;
      if_rdata_q  <= '0;
      d_rdata_q   <= '0;
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      we_q        <= we_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      if_ack_q    <= if_ack_d;
      d_ack_q     <= d_ack_d;
      if_rdata_q  <= if_rdata_d;
      d_rdata_q   <= d_rdata_d;
    end
  end

  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign if_ack    = if_ack_q;
  assign d_ack     = d_ack_q;
  assign if_rdata  = if_rdata_q;
  assign d_rdata   = d_rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: directed scenarios then randomized traffic,
// checked against a transaction-level model of the arbitration rules.
`timescale 1ns/1ps
module tb_mem_arbiter;

  localparam int AW = 6;
  localparam int DW = 32;
  localparam int SM = 4;
`ifdef MEM_ARB_RR_EN
  localparam int ST_EXP = 1;
`else
  localparam int ST_EXP = SM;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic [DW-1:0] if_rdata;
  logic          if_ack;
  logic          d_req;
  logic          d_we;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic [DW-1:0] d_rdata;
  logic          d_ack;
  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  always #5 clk = ~clk;

  mem_arbiter #(.AW(AW), .DW(DW), .STARVE_MAX(SM)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_ack(d_ack),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  typedef struct {
    int            cyc;
    bit            is_d;
    bit            we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] rdata;
  } xact_t;

  xact_t acc_q[$];
  xact_t ack_q[$];
  int errors = 0;
  int checks = 0;
  int cyc = 0;

  // Handshake from the stimulus process to the checker for the starvation scenario.
  int st_nd = 0;
  bit st_flag = 1'b0;

  function automatic logic [DW-1:0] init_word(input int a);
    if (a == 3) return 32'h00e22025;
    return DW'((a * 32'h0101_0101) ^ 32'h5a5a_0000);
  endfunction

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  // Memory device: synchronous read, data returned the cycle after mem_en.
  logic [DW-1:0] ram [0:(1<<AW)-1];
  initial begin
    for (int a = 0; a < (1 << AW); a++) ram[a] = init_word(a);
    mem_rdata = '0;
    forever begin
      @(posedge clk);
      if (mem_en) begin
        if (mem_we) ram[mem_addr] <= mem_wdata;
        else        mem_rdata <= ram[mem_addr];
      end
    end
  end

  // Reference model and monitor: evaluated once per cycle at the falling edge,
  // using the request inputs that the preceding rising edge sampled.
  logic [DW-1:0] ref_mem [0:(1<<AW)-1];
  initial begin
    xact_t e;
    bit win_d, e_en, e_ifa, e_da, mon_on, st_seen, m_last_d;
    int m_busy, m_starve;
    logic [DW-1:0] exp_if_rd, exp_d_rd;
    for (int a = 0; a < (1 << AW); a++) ref_mem[a] = init_word(a);
    mon_on = 1'b0; st_seen = 1'b0; m_last_d = 1'b0;
    m_busy = 0; m_starve = 0; exp_if_rd = '0; exp_d_rd = '0;
    forever begin
      @(negedge clk);
      cyc++;
      if (reset) begin
        acc_q.delete();
        ack_q.delete();
        m_busy = 0; m_starve = 0; m_last_d = 1'b0;
        exp_if_rd = '0; exp_d_rd = '0;
        mon_on = 1'b1;
        chk("rst_mem_en", DW'(mem_en), '0);
        chk("rst_mem_we", DW'(mem_we), '0);
        chk("rst_mem_addr", DW'(mem_addr), '0);
        chk("rst_mem_wdata", mem_wdata, '0);
        chk("rst_if_ack", DW'(if_ack), '0);
        chk("rst_d_ack", DW'(d_ack), '0);
        chk("rst_if_rdata", if_rdata, '0);
        chk("rst_d_rdata", d_rdata, '0);
      end else if (mon_on) begin
        if (m_busy > 0) m_busy--;
        if (m_busy == 0 && (if_req || d_req)) begin
`ifdef MEM_ARB_RR_EN
          win_d = (if_req && d_req) ? !m_last_d : d_req;
          m_last_d = win_d;
`else
          win_d = (if_req && d_req) ? (m_starve < SM) : d_req;
          m_starve = (win_d && if_req) ? ((m_starve < SM) ? m_starve + 1 : SM) : 0;
`endif
          e.cyc   = cyc;
          e.is_d  = win_d;
          e.we    = win_d && d_we;
          e.addr  = win_d ? d_addr : if_addr;
          e.wdata = win_d ? d_wdata : '0;
          e.rdata = ref_mem[e.addr];
          if (e.we) ref_mem[e.addr] = e.wdata;
          acc_q.push_back(e);
          e.cyc = cyc + 2;
          ack_q.push_back(e);
          m_busy = 3;
        end
        e_en = (acc_q.size() > 0) && (acc_q[0].cyc == cyc);
        chk("mem_en", DW'(mem_en), DW'(e_en));
        if (e_en) begin
          e = acc_q.pop_front();
          chk("mem_we", DW'(mem_we), DW'(e.we));
          chk("mem_addr", DW'(mem_addr), DW'(e.addr));
          chk("mem_wdata", mem_wdata, e.wdata);
        end else begin
          chk("mem_we_idle", DW'(mem_we), '0);
        end
        e_ifa = 1'b0; e_da = 1'b0;
        if ((ack_q.size() > 0) && (ack_q[0].cyc == cyc)) begin
          e = ack_q.pop_front();
          if (e.is_d) begin
            e_da = 1'b1;
            if (!e.we) exp_d_rd = e.rdata;
          end else begin
            e_ifa = 1'b1;
            exp_if_rd = e.rdata;
          end
        end
        chk("if_ack", DW'(if_ack), DW'(e_ifa));
        chk("d_ack", DW'(d_ack), DW'(e_da));
        chk("if_rdata", if_rdata, exp_if_rd);
        chk("d_rdata", d_rdata, exp_d_rd);
        if (st_flag != st_seen) begin
          st_seen = st_flag;
          chk("starve_data_grants", DW'(st_nd), DW'(ST_EXP));
        end
      end
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_ack(input bit want_d, input string name);
    for (int i = 0; i < 40; i++) begin
      step();
      if (want_d ? d_ack : if_ack) return;
    end
    $display("FAIL %s: no ack within 40 cycles", name);
    $fatal(1);
  endtask

  initial begin
    int nd;
    bit done;
    reset = 1'b1; if_req = 1'b0; if_addr = '0;
    d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
    repeat (3) step();
    reset = 1'b0;

    // Fetch only.
    if_addr = 6'h03; if_req = 1'b1;
    wait_ack(1'b0, "fetch_only");
    if_req = 1'b0;
    step(); step();

    // Simultaneous requests.
    if_addr = 6'h05; d_addr = 6'h09; d_we = 1'b0; if_req = 1'b1; d_req = 1'b1;
    wait_ack(1'b1, "tie_data");
    d_req = 1'b0;
    wait_ack(1'b0, "tie_fetch");
    if_req = 1'b0;
    step();

    // Data re-requesting back to back while fetch waits.
    nd = 0; done = 1'b0;
    if_addr = 6'h07; d_addr = 6'h10; if_req = 1'b1; d_req = 1'b1;
    for (int i = 0; i < 60 && !done; i++) begin
      step();
      if (d_ack) begin
        nd++;
        d_addr = AW'($urandom);
      end
      if (if_ack) done = 1'b1;
    end
    if (!done) begin
      $display("FAIL starvation: fetch never granted");
      $fatal(1);
    end
    if_req = 1'b0; d_req = 1'b0;
    st_nd = nd; st_flag = ~st_flag;
    step();

    // Store, then read it back.
    d_we = 1'b1; d_addr = 6'h14; d_wdata = 32'h0000_0008; d_req = 1'b1;
    wait_ack(1'b1, "store");
    d_we = 1'b0;
    wait_ack(1'b1, "load_back");
    d_req = 1'b0;
    step();

    // Reset while the access is in WAIT; the held fetch is re-arbitrated.
    if_addr = 6'h21; if_req = 1'b1;
    done = 1'b0;
    for (int i = 0; i < 10 && !done; i++) begin
      step();
      if (mem_en) done = 1'b1;
    end
    if (!done) begin
      $display("FAIL reset_wait: no access started");
      $fatal(1);
    end
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    wait_ack(1'b0, "after_reset");
    if_req = 1'b0;
    step();

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 1500; i++) begin
      step();
      reset = ($urandom_range(0, 199) == 0);
      if (if_req && if_ack) if_req = 1'b0;
      if (d_req && d_ack) d_req = 1'b0;
      if (!if_req && $urandom_range(0, 2) != 0) begin
        if_req = 1'b1; if_addr = AW'($urandom);
      end
      if (!d_req && $urandom_range(0, 2) != 0) begin
        d_req = 1'b1; d_we = 1'($urandom_range(0, 1));
        d_addr = AW'($urandom); d_wdata = $urandom;
      end
    end
    reset = 1'b0;
    done = 1'b0;
    for (int i = 0; i < 40 && !done; i++) begin
      step();
      if (if_req && if_ack) if_req = 1'b0;
      if (d_req && d_ack) d_req = 1'b0;
      if (!if_req && !d_req) done = 1'b1;
    end
    if (!done) begin
      $display("FAIL drain: requests still pending");
      $fatal(1);
    end
    repeat (5) step();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares one single-port, synchronous-read instruction/data memory between the fetch stage and the load/store stage of the MIPS core.
- Intended for the unified-memory multicycle/stalling variant of the CPU.
- Arbitrates between the two requesters, sequences each access through a fixed three-state FSM, and returns read data with a one-cycle ack pulse.
- Data accesses have priority. A starvation counter guarantees that fetch progresses.

Parameters:
AW, 6, word-address width (64-word memory)
DW, 32, data/instruction width
STARVE_MAX, 4, max consecutive data grants while if_req pending before fetch is forced

Ports:
clk  in  1  system clock, rising edge
reset  in  1  synchronous, active-high reset
if_req  in  1  fetch request; held with if_addr stable until if_ack
if_addr  in  AW  fetch word address
if_rdata  out  DW  fetched instruction, valid while if_ack=1
if_ack  out  1  one-cycle completion pulse for fetch
d_req  in  1  data request; held with d_we/d_addr/d_wdata stable until d_ack
d_we  in  1  1 = store, 0 = load
d_addr  in  AW  data word address
d_wdata  in  DW  store data
d_rdata  out  DW  load data, valid while d_ack=1
d_ack  out  1  one-cycle completion pulse for data
mem_en  out  1  memory access strobe
mem_we  out  1  memory write enable (data port only)
mem_addr  out  AW  memory word address
mem_wdata  out  DW  memory write data
mem_rdata  in  DW  memory read data, valid the cycle after mem_en

Behaviour:
- Clock and reset: one clock, clk; reset is synchronous and active-high.
- Reset values: state=IDLE, starve_cnt=0, and every output is 0: mem_en, mem_we, mem_addr, mem_wdata, if_ack, d_ack, if_rdata, d_rdata.
- All outputs are registered.
- FSM states: IDLE, ACCESS, WAIT.
- IDLE, no request: stay in IDLE; mem_* outputs are 0.
- IDLE, any request at edge E0:
  - Choose the winner.
  - Latch the winner's address, we and wdata into the mem_* registers.
  - Go to ACCESS.
- ACCESS (cycle after E0):
  - mem_en=1, with mem_we=d_we if data won, else 0.
  - At E1, go to WAIT and drop mem_en/mem_we.
- WAIT (cycle after E1):
  - mem_rdata is valid.
  - At E2, capture mem_rdata into the winner's rdata register, set the winner's ack to 1, and go to IDLE.
- Completion timing: ack is high in exactly the cycle after E2, then returns to 0.
- Latency: request sampled at E0 → ack visible 3 edges later. Peak throughput is one access per 3 cycles.
- Ack cycle: the arbiter is in IDLE. The requester must drop req or present its next request, which is sampled at E3.
- Winner selection: data wins ties unless starve_cnt==STARVE_MAX, in which case fetch wins.
- starve_cnt:
  - +1 on each data grant while if_req=1.
  - Cleared on a fetch grant.
  - Cleared on a data grant with if_req=0.
  - Saturates at STARVE_MAX.
- Stores: d_rdata holds its previous value; d_ack still pulses.
- Request inputs changing after the grant are ignored, because the access is latched.
- req dropped mid-transaction: the access still completes and ack still pulses; the requester discards it.
- The losing requester's ack stays 0 and its rdata is unchanged.
- Reset in ACCESS or WAIT: the transaction is abandoned with no ack, and all outputs are 0 the next cycle. A request still held after reset is re-arbitrated from IDLE.

Optional Feature:
- Macro: MEM_ARB_RR_EN.
- Defined:
  - Fixed priority and starve_cnt are replaced by round-robin on ties.
  - A last_gnt flop (reset value GNT_IF) selects the other requester when both are requesting.
  - A lone requester always wins.
- Undefined: data-priority with starvation guard, as above. The STARVE_MAX parameter is still present but unused when the macro is defined.

Decomposition:
- Package mem_arb_pkg:
  - typedef enum arb_state_t {IDLE, ACCESS, WAIT}.
  - typedef enum gnt_t {GNT_IF, GNT_D}.
  - Default width constants.
- Sub-module arb_select:
  - Inputs: if_req, d_req, the grant-taken strobe, clk/reset.
  - Output: winner (gnt_t).
  - Holds starve_cnt, or last_gnt under MEM_ARB_RR_EN.
- The FSM and datapath registers stay in mem_arbiter.

Test Plan:
1. Fetch only: if_req=1, if_addr=6'h03, memory returns 32'h00e22025 → mem_en=1 one cycle with mem_addr=6'h03, mem_we=0; if_ack pulses exactly 1 cycle, 3 edges after grant; if_rdata=32'h00e22025; d_ack stays 0.
2. Tie with starve_cnt=0: if_req and d_req asserted the same cycle → data served first, d_ack pulse; fetch granted at the next IDLE, if_ack 3 cycles after d_ack.
3. Starvation, STARVE_MAX=4: d_req held continuously, re-requesting after each ack, if_req held → exactly 4 data grants, then fetch granted 5th; starve_cnt returns to 0.
4. Store: d_we=1, d_addr=6'h14, d_wdata=32'h00000008 → one ACCESS cycle with mem_en=1, mem_we=1, mem_addr=6'h14, mem_wdata=32'h8; d_ack pulses; d_rdata unchanged; if_ack 0.
5. Reset asserted during WAIT → next cycle mem_en=0, no ack, FSM in IDLE; still-held if_req is granted afterwards with normal 3-edge latency.
6. MEM_ARB_RR_EN defined, both requests held continuously → grants alternate D,I,D,I,… starting with D (last_gnt reset value GNT_IF).
